// File: rtl/dmem_burst_responder_pkg.sv
// Shared encodings for the DMem burst responder: channel FSM states,
// write-status code and the full-word byte-enable pattern.
package dmem_resp_pkg;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_WAIT  = 2'd1;
  localparam logic [1:0] R_ISSUE = 2'd2;
  localparam logic [1:0] R_DRAIN = 2'd3;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_WAIT  = 2'd1;
  localparam logic [1:0] W_DATA  = 2'd2;
  localparam logic [1:0] W_RESP  = 2'd3;

  localparam logic       STATUS_OK = 1'b1;
  localparam logic [3:0] WBE_FULL  = 4'hF;

endpackage

// File: rtl/dmem_burst_responder_fifo.sv
// Synchronous show-ahead FIFO buffering read beats between DMem port A
// and the read-data channel.
module resp_fifo #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DWIDTH-1:0]        din,
  input  logic                     pop,
  output logic [DWIDTH-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    full     = (count_q == (PW+1)'(DEPTH));
    empty    = (count_q == '0);
    count    = count_q;
    dout     = mem_q[rd_ptr_q];
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + (PW+1)'(1);
    if (do_pop && !do_push) count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dmem_burst_responder.sv
// Memory-side burst responder: read bursts served from DMem port A through a
// response FIFO, write bursts streamed to port B; both after a fixed IO latency.
module dmem_burst_responder
  import dmem_resp_pkg::*;
#(
  parameter int AWIDTH      = 14,
  parameter int DWIDTH      = 32,
  parameter int IO_LATENCY  = 10,
  parameter int RFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] req_read_addr,
  input  logic [31:0]       req_read_len,
  input  logic              req_read_addr_valid,
  output logic              req_read_addr_ready,
  output logic [DWIDTH-1:0] resp_read_data,
  output logic              resp_read_data_valid,
  input  logic              resp_read_data_ready,
  input  logic [AWIDTH-1:0] req_write_addr,
  input  logic [31:0]       req_write_len,
  input  logic              req_write_addr_valid,
  output logic              req_write_addr_ready,
  input  logic [DWIDTH-1:0] req_write_data,
  input  logic              req_write_data_valid,
  output logic              req_write_data_ready,
  output logic              resp_write_status,
  output logic              resp_write_status_valid,
  input  logic              resp_write_status_ready,
  output logic [AWIDTH-1:0] dmem_addra,
  output logic [DWIDTH-1:0] dmem_dina,
  output logic [3:0]        dmem_wea,
  input  logic [DWIDTH-1:0] dmem_douta,
  output logic [AWIDTH-1:0] dmem_addrb,
  output logic [DWIDTH-1:0] dmem_dinb,
  output logic [3:0]        dmem_web,
  input  logic [DWIDTH-1:0] dmem_doutb
);

  localparam logic [31:0] LAT    = IO_LATENCY;
  localparam logic [31:0] RDEPTH = RFIFO_DEPTH;
  localparam int          CW     = $clog2(RFIFO_DEPTH) + 1;

  logic              arm_q, arm_d;

  logic [1:0]        rd_state_q, rd_state_d;
  logic [AWIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [31:0]       rd_left_q, rd_left_d;
  logic [31:0]       rd_wait_q, rd_wait_d;
  logic              rd_inflight_q, rd_inflight_d;
  logic              rd_issue;

  logic [1:0]        wr_state_q, wr_state_d;
  logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_left_q, wr_left_d;
  logic [31:0]       wr_wait_q, wr_wait_d;
  logic              wr_beat;

  logic              fifo_pop, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              unused_fifo_full;
  logic              unused_doutb;

  assign unused_doutb = ^dmem_doutb;

  resp_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (RFIFO_DEPTH)
  ) u_rfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_inflight_q),
    .din   (dmem_douta),
    .pop   (fifo_pop),
    .dout  (resp_read_data),
    .full  (unused_fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Address-ready stays low through reset and rises on the first edge after release.
  always_comb begin
    arm_d = 1'b1;
  end

  always_comb begin
    rd_state_d           = rd_state_q;
    rd_addr_d            = rd_addr_q;
    rd_left_d            = rd_left_q;
    rd_wait_d            = rd_wait_q;
    rd_issue             = 1'b0;
    req_read_addr_ready  = arm_q && (rd_state_q == R_IDLE);
    resp_read_data_valid = !fifo_empty;
    fifo_pop             = resp_read_data_valid && resp_read_data_ready;
    dmem_addra           = rd_addr_q;
    dmem_dina            = '0;
    dmem_wea             = '0;
    case (rd_state_q)
      R_IDLE: begin
        if (req_read_addr_valid && req_read_addr_ready) begin
          rd_addr_d = req_read_addr;
          rd_left_d = req_read_len;
          rd_wait_d = LAT;
          if (req_read_len == '0) rd_state_d = R_IDLE;
          else if (LAT == '0)     rd_state_d = R_ISSUE;
          else                    rd_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        rd_wait_d = rd_wait_q - 32'd1;
        if (rd_wait_q <= 32'd1) rd_state_d = R_ISSUE;
      end
      R_ISSUE: begin
        // Reserve a FIFO slot for every read still in flight from port A.
        if (32'(fifo_count) + 32'(rd_inflight_q) < RDEPTH) begin
          rd_issue  = 1'b1;
          rd_addr_d = rd_addr_q + AWIDTH'(1);
          rd_left_d = rd_left_q - 32'd1;
          if (rd_left_q == 32'd1) rd_state_d = R_DRAIN;
        end
      end
      R_DRAIN: begin
        if (fifo_empty && !rd_inflight_q) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
    rd_inflight_d = rd_issue;
  end

  always_comb begin
    wr_state_d              = wr_state_q;
    wr_addr_d               = wr_addr_q;
    wr_left_d               = wr_left_q;
    wr_wait_d               = wr_wait_q;
    req_write_addr_ready    = arm_q && (wr_state_q == W_IDLE);
    req_write_data_ready    = (wr_state_q == W_DATA);
    wr_beat                 = req_write_data_ready && req_write_data_valid;
    dmem_addrb              = wr_addr_q;
    dmem_dinb               = wr_beat ? req_write_data : '0;
    dmem_web                = wr_beat ? WBE_FULL : 4'h0;
    resp_write_status_valid = (wr_state_q == W_RESP);
    resp_write_status       = resp_write_status_valid ? STATUS_OK : 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (req_write_addr_valid && req_write_addr_ready) begin
          wr_addr_d = req_write_addr;
          wr_left_d = req_write_len;
          wr_wait_d = LAT;
          if (LAT != '0)               wr_state_d = W_WAIT;
          else if (req_write_len == '0) wr_state_d = W_RESP;
          else                         wr_state_d = W_DATA;
        end
      end
      W_WAIT: begin
        wr_wait_d = wr_wait_q - 32'd1;
        if (wr_wait_q <= 32'd1) wr_state_d = (wr_left_q == '0) ? W_RESP : W_DATA;
      end
      W_DATA: begin
        if (wr_beat) begin
          wr_addr_d = wr_addr_q + AWIDTH'(1);
          wr_left_d = wr_left_q - 32'd1;
          if (wr_left_q == 32'd1) wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (resp_write_status_ready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arm_q         <= 1'b0;
      rd_state_q    <= R_IDLE;
      rd_addr_q     <= '0;
      rd_left_q     <= '0;
      rd_wait_q     <= '0;
      rd_inflight_q <= 1'b0;
      wr_state_q    <= W_IDLE;
      wr_addr_q     <= '0;
      wr_left_q     <= '0;
      wr_wait_q     <= '0;
    end else begin
      arm_q         <= arm_d;
      rd_state_q    <= rd_state_d;
      rd_addr_q     <= rd_addr_d;
      rd_left_q     <= rd_left_d;
      rd_wait_q     <= rd_wait_d;
      rd_inflight_q <= rd_inflight_d;
      wr_state_q    <= wr_state_d;
      wr_addr_q     <= wr_addr_d;
      wr_left_q     <= wr_left_d;
      wr_wait_q     <= wr_wait_d;
    end
  end

endmodule

// File: tb/tb_dmem_burst_responder.sv
// Bench for dmem_burst_responder: a behavioural DMem plus a word-level
// reference memory updated from burst rules, exercised with random traffic.
module tb_dmem_burst_responder;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int LAT   = 10;
  localparam int DEPTH = 4;
  localparam int MSIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] req_read_addr = '0;
  logic [31:0]   req_read_len = '0;
  logic          req_read_addr_valid = 1'b0, req_read_addr_ready;
  logic [DW-1:0] resp_read_data;
  logic          resp_read_data_valid, resp_read_data_ready = 1'b0;
  logic [AW-1:0] req_write_addr = '0;
  logic [31:0]   req_write_len = '0;
  logic          req_write_addr_valid = 1'b0, req_write_addr_ready;
  logic [DW-1:0] req_write_data = '0;
  logic          req_write_data_valid = 1'b0, req_write_data_ready;
  logic          resp_write_status, resp_write_status_valid;
  logic          resp_write_status_ready = 1'b0;
  logic [AW-1:0] dmem_addra, dmem_addrb;
  logic [DW-1:0] dmem_dina, dmem_douta, dmem_dinb, dmem_doutb;
  logic [3:0]    dmem_wea, dmem_web;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_count = 0;

  logic [DW-1:0] mem [MSIZE];
  bit            written [MSIZE];
  logic [DW-1:0] exp_mem [MSIZE];
  logic [DW-1:0] rd_got [$];
  logic [DW-1:0] wr_data [$];
  logic [DW-1:0] wtmp;

  dmem_burst_responder #(
    .AWIDTH(AW), .DWIDTH(DW), .IO_LATENCY(LAT), .RFIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_read_addr(req_read_addr), .req_read_len(req_read_len),
    .req_read_addr_valid(req_read_addr_valid), .req_read_addr_ready(req_read_addr_ready),
    .resp_read_data(resp_read_data), .resp_read_data_valid(resp_read_data_valid),
    .resp_read_data_ready(resp_read_data_ready),
    .req_write_addr(req_write_addr), .req_write_len(req_write_len),
    .req_write_addr_valid(req_write_addr_valid), .req_write_addr_ready(req_write_addr_ready),
    .req_write_data(req_write_data), .req_write_data_valid(req_write_data_valid),
    .req_write_data_ready(req_write_data_ready),
    .resp_write_status(resp_write_status), .resp_write_status_valid(resp_write_status_valid),
    .resp_write_status_ready(resp_write_status_ready),
    .dmem_addra(dmem_addra), .dmem_dina(dmem_dina), .dmem_wea(dmem_wea), .dmem_douta(dmem_douta),
    .dmem_addrb(dmem_addrb), .dmem_dinb(dmem_dinb), .dmem_web(dmem_web), .dmem_doutb(dmem_doutb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [DW-1:0] peek(input logic [AW-1:0] a);
    return written[a] ? mem[a] : init_word(a);
  endfunction

  // Dual-port synchronous DMem: one-cycle read on A, byte-enabled write on B.
  always @(posedge clk) begin
    dmem_douta <= peek(dmem_addra);
    dmem_doutb <= peek(dmem_addrb);
    if (dmem_web != 4'h0) begin
      wtmp = peek(dmem_addrb);
      for (int b = 0; b < 4; b++) if (dmem_web[b]) wtmp[8*b +: 8] = dmem_dinb[8*b +: 8];
      mem[dmem_addrb]     <= wtmp;
      written[dmem_addrb] <= 1'b1;
      wr_count            <= wr_count + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic model_write(input logic [AW-1:0] a, input int len);
    for (int i = 0; i < len; i++) exp_mem[AW'(a + AW'(i))] = wr_data[i];
  endtask

  // mode 0: always ready, 1: toggling with a 20-cycle stall, 2: random.
  task automatic read_burst(input logic [AW-1:0] a, input int len, input int mode,
                            output int lat, output int unstable, output int extra,
                            output int span, output bit tmo);
    int t, k, acc, fc;
    bit held, rr;
    logic [DW-1:0] hd;
    rd_got.delete();
    lat = -1; unstable = 0; extra = 0; span = -1; tmo = 0; held = 0; hd = '0; fc = 0;
    @(negedge clk);
    req_read_addr = a; req_read_len = 32'(len); req_read_addr_valid = 1'b1;
    t = 0;
    while (!req_read_addr_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin tmo = 1; req_read_addr_valid = 1'b0; return; end
    acc = cyc + 1;
    @(negedge clk);
    req_read_addr_valid = 1'b0;
    k = 0;
    while (rd_got.size() < len && k < 4000) begin
      if (resp_read_data_valid && lat < 0) lat = cyc - acc;
      if (held && (!resp_read_data_valid || resp_read_data !== hd)) unstable++;
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (k >= 6 && k < 26) ? 1'b0 : (k % 2 == 0);
        default: rr = ($urandom_range(0, 3) != 0);
      endcase
      resp_read_data_ready = rr;
      if (resp_read_data_valid && rr) begin
        if (rd_got.size() == 0) fc = cyc;
        rd_got.push_back(resp_read_data);
        span = cyc - fc;
      end
      held = resp_read_data_valid && !rr;
      hd = resp_read_data;
      @(negedge clk);
      k++;
    end
    if (rd_got.size() < len) tmo = 1;
    resp_read_data_ready = 1'b1;
    for (int i = 0; i < LAT + 8; i++) begin
      if (resp_read_data_valid) extra++;
      @(negedge clk);
    end
    resp_read_data_ready = 1'b0;
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input int len, input int gapmax,
                             input int stall, output int first_lat, output int pulses,
                             output int bad_status, output bit tmo);
    int t, k, i, acc;
    first_lat = -1; pulses = 0; bad_status = 0; tmo = 0;
    @(negedge clk);
    req_write_addr = a; req_write_len = 32'(len); req_write_addr_valid = 1'b1;
    t = 0;
    while (!req_write_addr_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin tmo = 1; req_write_addr_valid = 1'b0; return; end
    acc = cyc + 1;
    @(negedge clk);
    req_write_addr_valid = 1'b0;
    i = 0; k = 0;
    while (i < len && k < 4000) begin
      if (i == 0 || $urandom_range(0, gapmax) == 0) begin
        req_write_data_valid = 1'b1; req_write_data = wr_data[i];
      end else begin
        req_write_data_valid = 1'b0; req_write_data = $urandom;
      end
      if (req_write_data_valid && req_write_data_ready) begin
        if (i == 0) first_lat = cyc + 1 - acc;
        i++;
      end
      @(negedge clk);
      k++;
    end
    req_write_data_valid = 1'b0;
    if (i < len) begin tmo = 1; return; end
    t = 0;
    while (!resp_write_status_valid && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin tmo = 1; return; end
    resp_write_status_ready = 1'b0;
    for (int j = 0; j < stall; j++) begin
      if (!resp_write_status_valid || resp_write_status !== 1'b1) bad_status++;
      @(negedge clk);
    end
    if (resp_write_status !== 1'b1) bad_status++;
    resp_write_status_ready = 1'b1;
    pulses = 1;
    @(negedge clk);
    resp_write_status_ready = 1'b0;
    for (int j = 0; j < LAT + 8; j++) begin
      if (resp_write_status_valid) pulses++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({req_read_addr_ready, req_write_addr_ready} !== 2'b00) begin
      n_bad++; $display("FAIL reset_addr_ready: got %b expected 00", {req_read_addr_ready, req_write_addr_ready});
    end
    n_cmp++;
    if ({resp_read_data_valid, resp_write_status_valid, req_write_data_ready, resp_write_status} !== 4'b0) begin
      n_bad++; $display("FAIL reset_valids: got %b expected 0000",
                        {resp_read_data_valid, resp_write_status_valid, req_write_data_ready, resp_write_status});
    end
    n_cmp++;
    if (dmem_web !== 4'h0 || dmem_wea !== 4'h0) begin
      n_bad++; $display("FAIL reset_we: got web=%h wea=%h expected 0", dmem_web, dmem_wea);
    end
    n_cmp++;
    if (dmem_addra !== '0 || dmem_addrb !== '0 || dmem_dina !== '0) begin
      n_bad++; $display("FAIL reset_addr: got a=%h b=%h dina=%h expected 0", dmem_addra, dmem_addrb, dmem_dina);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({req_read_addr_ready, req_write_addr_ready} !== 2'b00) begin
      n_bad++; $display("FAIL release_before_edge: got %b expected 00", {req_read_addr_ready, req_write_addr_ready});
    end
    @(negedge clk);
    n_cmp++;
    if ({req_read_addr_ready, req_write_addr_ready} !== 2'b11) begin
      n_bad++; $display("FAIL release_after_edge: got %b expected 11", {req_read_addr_ready, req_write_addr_ready});
    end
  endtask

  task automatic test_single_read();
    int lat, uns, extra, span;
    bit tmo;
    read_burst(AW'(100), 4, 0, lat, uns, extra, span, tmo);
    n_cmp++;
    if (tmo || rd_got.size() != 4) begin
      n_bad++; $display("FAIL single_read_count: got %0d beats tmo=%0d expected 4", rd_got.size(), tmo);
    end
    for (int i = 0; i < rd_got.size(); i++) begin
      n_cmp++;
      if (rd_got[i] !== exp_mem[AW'(100 + i)]) begin
        n_bad++; $display("FAIL single_read_beat%0d: got %h expected %h", i, rd_got[i], exp_mem[AW'(100 + i)]);
      end
    end
    n_cmp++;
    if (lat != LAT + 2) begin n_bad++; $display("FAIL single_read_latency: got %0d expected %0d", lat, LAT + 2); end
    n_cmp++;
    if (span != 3) begin n_bad++; $display("FAIL single_read_back_to_back: got span %0d expected 3", span); end
    n_cmp++;
    if (extra != 0) begin n_bad++; $display("FAIL single_read_extra: got %0d expected 0", extra); end
  endtask

  task automatic test_backpressure();
    int lat, uns, extra, span;
    bit tmo;
    logic [AW-1:0] a;
    a = AW'($urandom_range(300, 9000));
    read_burst(a, 8, 1, lat, uns, extra, span, tmo);
    n_cmp++;
    if (tmo || rd_got.size() != 8) begin
      n_bad++; $display("FAIL bp_count: got %0d beats tmo=%0d expected 8", rd_got.size(), tmo);
    end
    for (int i = 0; i < rd_got.size(); i++) begin
      n_cmp++;
      if (rd_got[i] !== exp_mem[AW'(a + AW'(i))]) begin
        n_bad++; $display("FAIL bp_beat%0d: got %h expected %h", i, rd_got[i], exp_mem[AW'(a + AW'(i))]);
      end
    end
    n_cmp++;
    if (uns != 0) begin n_bad++; $display("FAIL bp_hold_stable: got %0d changes expected 0", uns); end
    n_cmp++;
    if (extra != 0) begin n_bad++; $display("FAIL bp_extra: got %0d expected 0", extra); end
  endtask

  task automatic test_write_burst();
    int flat, pulses, bad, lat, uns, extra, span;
    bit tmo;
    wr_data = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    write_burst(AW'(200), 5, 2, 3, flat, pulses, bad, tmo);
    model_write(AW'(200), 5);
    n_cmp++;
    if (tmo) begin n_bad++; $display("FAIL wr_timeout: got tmo=1 expected 0"); end
    n_cmp++;
    if (flat != LAT + 1) begin n_bad++; $display("FAIL wr_first_beat_latency: got %0d expected %0d", flat, LAT + 1); end
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL wr_status_pulses: got %0d expected 1", pulses); end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL wr_status_hold: got %0d bad cycles expected 0", bad); end
    for (int i = 199; i <= 205; i++) begin
      n_cmp++;
      if (peek(AW'(i)) !== exp_mem[AW'(i)]) begin
        n_bad++; $display("FAIL wr_mem[%0d]: got %h expected %h", i, peek(AW'(i)), exp_mem[AW'(i)]);
      end
    end
    read_burst(AW'(200), 5, 2, lat, uns, extra, span, tmo);
    n_cmp++;
    if (rd_got.size() != 5 || rd_got[0] !== 32'd1 || rd_got[4] !== 32'd5) begin
      n_bad++; $display("FAIL wr_readback: got %0d beats first=%h last=%h expected 5 beats 1..5",
                        rd_got.size(), rd_got.size() > 0 ? rd_got[0] : '0, rd_got.size() > 4 ? rd_got[4] : '0);
    end
  endtask

  task automatic test_wrap_zero();
    int flat, pulses, bad, lat, uns, extra, span, wc0;
    bit tmo;
    wr_data.delete();
    for (int i = 0; i < 4; i++) wr_data.push_back($urandom);
    write_burst(AW'(16382), 4, 1, 0, flat, pulses, bad, tmo);
    model_write(AW'(16382), 4);
    n_cmp++;
    if (tmo || pulses != 1) begin n_bad++; $display("FAIL wrap_wr_status: got pulses=%0d tmo=%0d expected 1/0", pulses, tmo); end
    for (int i = -1; i <= 4; i++) begin
      n_cmp++;
      if (peek(AW'(16382 + i)) !== exp_mem[AW'(16382 + i)]) begin
        n_bad++; $display("FAIL wrap_mem[%0d]: got %h expected %h", (16382 + i) % MSIZE,
                          peek(AW'(16382 + i)), exp_mem[AW'(16382 + i)]);
      end
    end
    read_burst(AW'(16382), 4, 0, lat, uns, extra, span, tmo);
    n_cmp++;
    if (rd_got.size() != 4 || rd_got[2] !== exp_mem[0] || rd_got[3] !== exp_mem[1]) begin
      n_bad++; $display("FAIL wrap_read: got %0d beats b2=%h expected 4 beats b2=%h", rd_got.size(),
                        rd_got.size() > 2 ? rd_got[2] : '0, exp_mem[0]);
    end
    read_burst(AW'($urandom_range(0, MSIZE - 1)), 0, 0, lat, uns, extra, span, tmo);
    n_cmp++;
    if (tmo || rd_got.size() != 0 || extra != 0) begin
      n_bad++; $display("FAIL zero_read_beats: got %0d beats + %0d extra tmo=%0d expected 0",
                        rd_got.size(), extra, tmo);
    end
    n_cmp++;
    if (req_read_addr_ready !== 1'b1) begin n_bad++; $display("FAIL zero_read_ready: got %b expected 1", req_read_addr_ready); end
    wc0 = wr_count;
    write_burst(AW'($urandom_range(0, MSIZE - 1)), 0, 0, 1, flat, pulses, bad, tmo);
    n_cmp++;
    if (tmo || pulses != 1 || bad != 0) begin
      n_bad++; $display("FAIL zero_write_status: got pulses=%0d bad=%0d tmo=%0d expected 1/0/0", pulses, bad, tmo);
    end
    n_cmp++;
    if (wr_count != wc0) begin n_bad++; $display("FAIL zero_write_mem: got %0d writes expected 0", wr_count - wc0); end
  endtask

  task automatic test_concurrency();
    int lat, uns, extra, span, flat, pulses, bad, rd_err, wr_err;
    bit rtmo, wtmo;
    logic [AW-1:0] x, y;
    x = AW'($urandom_range(1000, 2000));
    y = AW'($urandom_range(5000, 6000));
    wr_data.delete();
    for (int i = 0; i < 64; i++) wr_data.push_back($urandom);
    fork
      read_burst(x, 64, 2, lat, uns, extra, span, rtmo);
      write_burst(y, 64, 1, 1, flat, pulses, bad, wtmo);
    join
    model_write(y, 64);
    rd_err = 0; wr_err = 0;
    for (int i = 0; i < rd_got.size(); i++) if (rd_got[i] !== exp_mem[AW'(x + AW'(i))]) rd_err++;
    for (int i = -1; i <= 64; i++) if (peek(AW'(y + AW'(i))) !== exp_mem[AW'(y + AW'(i))]) wr_err++;
    n_cmp++;
    if (rtmo || rd_got.size() != 64 || rd_err != 0 || uns != 0) begin
      n_bad++; $display("FAIL conc_read: got %0d beats, %0d wrong, %0d unstable expected 64/0/0",
                        rd_got.size(), rd_err, uns);
    end
    n_cmp++;
    if (wtmo || pulses != 1 || wr_err != 0) begin
      n_bad++; $display("FAIL conc_write: got pulses=%0d wrong_words=%0d tmo=%0d expected 1/0/0", pulses, wr_err, wtmo);
    end
  endtask

  task automatic test_reset_mid_write();
    int i, k, wc0, flat, pulses, bad;
    bit tmo;
    logic [AW-1:0] a;
    logic [DW-1:0] d [6];
    a = AW'($urandom_range(3000, 4000));
    for (int j = 0; j < 6; j++) d[j] = $urandom;
    @(negedge clk);
    req_write_addr = a; req_write_len = 32'd6; req_write_addr_valid = 1'b1;
    k = 0;
    while (!req_write_addr_ready && k < 200) begin @(negedge clk); k++; end
    @(negedge clk);
    req_write_addr_valid = 1'b0;
    wc0 = wr_count; i = 0; k = 0;
    while (i < 2 && k < 200) begin
      req_write_data = d[i]; req_write_data_valid = 1'b1;
      if (req_write_data_ready) begin @(negedge clk); i++; end
      else @(negedge clk);
      k++;
    end
    n_cmp++;
    if (i != 2) begin n_bad++; $display("FAIL rst_mid_beats: got %0d accepted expected 2", i); end
    req_write_data = d[2];
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({resp_read_data_valid, resp_write_status_valid, req_write_data_ready,
         req_read_addr_ready, req_write_addr_ready} !== 5'b0 || dmem_web !== 4'h0) begin
      n_bad++; $display("FAIL rst_mid_outputs: got valids/readies=%b web=%h expected 0",
                        {resp_read_data_valid, resp_write_status_valid, req_write_data_ready,
                         req_read_addr_ready, req_write_addr_ready}, dmem_web);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req_write_data_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (wr_count - wc0 != 2) begin n_bad++; $display("FAIL rst_mid_writes: got %0d writes expected 2", wr_count - wc0); end
    exp_mem[a] = d[0];
    exp_mem[AW'(a + AW'(1))] = d[1];
    for (int j = -1; j <= 6; j++) begin
      n_cmp++;
      if (peek(AW'(a + AW'(j))) !== exp_mem[AW'(a + AW'(j))]) begin
        n_bad++; $display("FAIL rst_mid_mem[+%0d]: got %h expected %h", j, peek(AW'(a + AW'(j))), exp_mem[AW'(a + AW'(j))]);
      end
    end
    wr_data = {32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};
    write_burst(AW'(a + AW'(2)), 3, 1, 0, flat, pulses, bad, tmo);
    model_write(AW'(a + AW'(2)), 3);
    n_cmp++;
    if (tmo || pulses != 1 || bad != 0) begin
      n_bad++; $display("FAIL post_rst_write: got pulses=%0d bad=%0d tmo=%0d expected 1/0/0", pulses, bad, tmo);
    end
    for (int j = 2; j <= 4; j++) begin
      n_cmp++;
      if (peek(AW'(a + AW'(j))) !== exp_mem[AW'(a + AW'(j))]) begin
        n_bad++; $display("FAIL post_rst_mem[+%0d]: got %h expected %h", j, peek(AW'(a + AW'(j))), exp_mem[AW'(a + AW'(j))]);
      end
    end
  endtask

  task automatic test_final_memory();
    int diffs;
    diffs = 0;
    for (int i = 0; i < MSIZE; i++) if (peek(AW'(i)) !== exp_mem[i]) diffs++;
    n_cmp++;
    if (diffs != 0) begin n_bad++; $display("FAIL final_memory: got %0d differing words expected 0", diffs); end
  endtask

  initial begin
    for (int i = 0; i < MSIZE; i++) exp_mem[i] = init_word(AW'(i));
    rst = 1'b1;
    #1 rst = 1'b0;
    test_reset();
    test_single_read();
    test_backpressure();
    test_write_burst();
    test_wrap_zero();
    test_concurrency();
    test_reset_mid_write();
    test_final_memory();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
